// File: rtl/cal_module_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cal_module_initiator                                       |
// | Description : Initiator side of the MBINIT CAL sideband handshake.       |
// |               Sends MSG_CAL_DONE_REQ once the sideband is free and waits |
// |               for MSG_CAL_DONE_RESP. Each attempt times out after        |
// |               TIMEOUT_CYCLES; MAX_RETRY re-sends are allowed before the  |
// |               sticky timeout flag is raised. Completion also waits for   |
// |               the local responder side to finish.                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   CLK                            in   clock, rising edge                 |
// |   rst_n                          in   asynchronous active-low reset      |
// |   i_MBINIT_PARAM_end             in   enable, high while CAL is active   |
// |   i_RX_SbMessage[3:0]            in   received sideband message code     |
// |   i_msg_valid                    in   i_RX_SbMessage valid this cycle    |
// |   i_Busy_SideBand                in   sideband TX busy                   |
// |   i_falling_edge_busy            in   pulse: our message has been sent   |
// |   i_MBINIT_CAL_ModulePartner_end in   local responder side finished      |
// |   o_TX_SbMessage[3:0]            out  message to transmit                |
// |   o_ValidOutDatat_Module         out  o_TX_SbMessage valid               |
// |   o_MBINIT_CAL_Module_end        out  whole CAL handshake complete       |
// |   o_CAL_timeout                  out  sticky failure, retries exhausted  |
// +--------------------------------------------------------------------------+
module cal_module_initiator #(
  parameter logic [15:0] TIMEOUT_CYCLES    = 16'd8000,
  parameter int          MAX_RETRY         = 2,
  parameter logic [3:0]  MSG_CAL_DONE_REQ  = 4'b0001,
  parameter logic [3:0]  MSG_CAL_DONE_RESP = 4'b0010
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       i_MBINIT_PARAM_end,
  input  logic [3:0] i_RX_SbMessage,
  input  logic       i_msg_valid,
  input  logic       i_Busy_SideBand,
  input  logic       i_falling_edge_busy,
  input  logic       i_MBINIT_CAL_ModulePartner_end,
  output logic [3:0] o_TX_SbMessage,
  output logic       o_ValidOutDatat_Module,
  output logic       o_MBINIT_CAL_Module_end,
  output logic       o_CAL_timeout
);

  localparam int                 CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 16'd1);
  localparam logic [CNT_W-1:0]   CNT_MAX     = CNT_W'(TIMEOUT_CYCLES);
  // One spare code so the counter can hold MAX_RETRY itself (and is never 0 bits wide).
  localparam int                 RETRY_W     = $clog2(MAX_RETRY + 2);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    WAIT_BUS_FREE = 3'd1,
    SEND_REQ      = 3'd2,
    WAIT_RESP     = 3'd3,
    WAIT_PARTNER  = 3'd4,
    DONE          = 3'd5,
    ERROR         = 3'd6
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry_cnt;
  logic               resp_seen;
  logic               resp_now;
  logic               timeout_hit;
  logic               retry_inc;

  assign resp_now    = i_msg_valid && (i_RX_SbMessage == MSG_CAL_DONE_RESP);
  assign timeout_hit = (state == WAIT_RESP) && (cnt == CNT_LAST);

  // State register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode. Losing the enable overrides every other transition.
  always_comb begin
    next_state = state;
    retry_inc  = 1'b0;
    if ((state != IDLE) && !i_MBINIT_PARAM_end) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (i_MBINIT_PARAM_end) next_state = WAIT_BUS_FREE;
        end
        WAIT_BUS_FREE: begin
          if (!i_Busy_SideBand) next_state = SEND_REQ;
        end
        SEND_REQ: begin
          // A response that beat our own send-complete pulse skips the wait.
          if (i_falling_edge_busy) begin
            next_state = resp_seen ? WAIT_PARTNER : WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          // A response arriving on the timeout cycle still wins.
          if (resp_seen || resp_now) begin
            if (resp_seen && i_MBINIT_CAL_ModulePartner_end) begin
              next_state = DONE;
            end else begin
              next_state = WAIT_PARTNER;
            end
          end else if (timeout_hit) begin
            if (retry_cnt < RETRY_LIMIT) begin
              retry_inc  = 1'b1;
              next_state = WAIT_BUS_FREE;
            end else begin
              next_state = ERROR;
            end
          end
        end
        WAIT_PARTNER: begin
          if (i_MBINIT_CAL_ModulePartner_end) next_state = DONE;
        end
        DONE:    next_state = DONE;
        ERROR:   next_state = ERROR;
        default: next_state = IDLE;
      endcase
    end
  end

  // Attempt timer: held at zero outside WAIT_RESP, so it restarts on every
  // entry; saturates rather than wrapping.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state != WAIT_RESP) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Retry count survives across attempts; only a return to IDLE clears it.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= '0;
    end else if (state == IDLE) begin
      retry_cnt <= '0;
    end else if (retry_inc) begin
      retry_cnt <= retry_cnt + RETRY_W'(1);
    end
  end

  // Response latch: only meaningful while a request is outstanding.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      resp_seen <= 1'b0;
    end else if (state == IDLE) begin
      resp_seen <= 1'b0;
    end else if (((state == SEND_REQ) || (state == WAIT_RESP)) && resp_now) begin
      resp_seen <= 1'b1;
    end
  end

  // Registered outputs decoded from next_state.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      o_TX_SbMessage          <= 4'b0000;
      o_ValidOutDatat_Module  <= 1'b0;
      o_MBINIT_CAL_Module_end <= 1'b0;
      o_CAL_timeout           <= 1'b0;
    end else begin
      o_TX_SbMessage          <= (next_state == SEND_REQ) ? MSG_CAL_DONE_REQ : 4'b0000;
      o_ValidOutDatat_Module  <= (next_state == SEND_REQ);
      o_MBINIT_CAL_Module_end <= (next_state == DONE);
      o_CAL_timeout           <= (next_state == ERROR);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cal_module_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cal_module_initiator                                    |
// | Description : Self-checking bench for cal_module_initiator. A phase-     |
// |               level reference model predicts the registered outputs each |
// |               cycle; directed scenarios add literal expectations.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cal_module_initiator;

  localparam logic [15:0] TO_P      = 16'd10;
  localparam int          T         = 10;
  localparam int          MR        = 2;
  localparam logic [3:0]  REQ_CODE  = 4'b0001;
  localparam logic [3:0]  RESP_CODE = 4'b0010;

  logic       CLK     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       en      = 1'b0;
  logic [3:0] rx      = 4'b0000;
  logic       mv      = 1'b0;
  logic       busy    = 1'b1;
  logic       fe      = 1'b0;
  logic       partner = 1'b0;
  logic [3:0] tx;
  logic       vout;
  logic       mend;
  logic       mto;

  always #5 CLK = ~CLK;

  cal_module_initiator #(
    .TIMEOUT_CYCLES    (TO_P),
    .MAX_RETRY         (MR),
    .MSG_CAL_DONE_REQ  (REQ_CODE),
    .MSG_CAL_DONE_RESP (RESP_CODE)
  ) dut (
    .CLK                            (CLK),
    .rst_n                          (rst_n),
    .i_MBINIT_PARAM_end             (en),
    .i_RX_SbMessage                 (rx),
    .i_msg_valid                    (mv),
    .i_Busy_SideBand                (busy),
    .i_falling_edge_busy            (fe),
    .i_MBINIT_CAL_ModulePartner_end (partner),
    .o_TX_SbMessage                 (tx),
    .o_ValidOutDatat_Module         (vout),
    .o_MBINIT_CAL_Module_end        (mend),
    .o_CAL_timeout                  (mto)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   valid_cycles;
  int   windows;
  logic prev_valid = 1'b0;

  // Reference model: handshake phase, response-heard flag, retries used,
  // and cycles spent waiting in the current attempt.
  localparam int PH_IDLE = 0, PH_BUS = 1, PH_REQ = 2, PH_WAIT = 3,
                 PH_PART = 4, PH_DONE = 5, PH_FAIL = 6;
  int m_phase   = PH_IDLE;
  bit m_heard   = 1'b0;
  int m_retries = 0;
  int m_waited  = 0;

  task automatic model_reset();
    m_phase   = PH_IDLE;
    m_heard   = 1'b0;
    m_retries = 0;
    m_waited  = 0;
  endtask

  task automatic model_step();
    bit resp;
    int nxt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    resp = mv && (rx == RESP_CODE);
    nxt  = m_phase;
    if (m_phase != PH_IDLE && !en) begin
      nxt = PH_IDLE;
    end else if (m_phase == PH_IDLE) begin
      if (en) nxt = PH_BUS;
    end else if (m_phase == PH_BUS) begin
      if (!busy) nxt = PH_REQ;
    end else if (m_phase == PH_REQ) begin
      if (fe) nxt = m_heard ? PH_PART : PH_WAIT;
    end else if (m_phase == PH_WAIT) begin
      if (m_heard || resp) nxt = (m_heard && partner) ? PH_DONE : PH_PART;
      else if (m_waited == T - 1) begin
        if (m_retries < MR) begin
          m_retries++;
          nxt = PH_BUS;
        end else begin
          nxt = PH_FAIL;
        end
      end
    end else if (m_phase == PH_PART) begin
      if (partner) nxt = PH_DONE;
    end
    if (m_phase == PH_IDLE) begin
      m_heard   = 1'b0;
      m_retries = 0;
    end else if ((m_phase == PH_REQ || m_phase == PH_WAIT) && resp) begin
      m_heard = 1'b1;
    end
    m_waited = (m_phase == PH_WAIT) ? m_waited + 1 : 0;
    m_phase  = nxt;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_nib(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_nib("model_tx", tx, (m_phase == PH_REQ) ? REQ_CODE : 4'b0000);
    check_bit("model_valid", vout, m_phase == PH_REQ);
    check_bit("model_end", mend, m_phase == PH_DONE);
    check_bit("model_timeout", mto, m_phase == PH_FAIL);
    if (vout === 1'b1) valid_cycles++;
    if (vout === 1'b1 && prev_valid !== 1'b1) windows++;
    prev_valid = vout;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (vout !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (vout !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: request window not seen within 40 cycles", name);
    end
  endtask

  task automatic fe_pulse();
    fe = 1'b1;
    tick();
    fe = 1'b0;
  endtask

  task automatic disable_en();
    en = 1'b0;
    mv = 1'b0;
    tick();
    partner = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    valid_cycles = 0;
    windows      = 0;

    // Reset state
    model_reset();
    @(negedge CLK);
    check_outputs();
    repeat (3) tick();
    check_nib("reset_tx", tx, 4'b0000);
    check_bit("reset_valid", vout, 1'b0);
    rst_n = 1'b1;
    tick();

    // Normal handshake
    valid_cycles = 0; windows = 0;
    en = 1'b1; busy = 1'b0;
    wait_valid("t1_req");
    check_nib("t1_tx_code", tx, 4'b0001);
    tick(); tick();
    fe_pulse();
    repeat (4) tick();
    mv = 1'b1; rx = RESP_CODE; tick(); mv = 1'b0; rx = 4'b0000;
    partner = 1'b1;
    repeat (3) tick();
    check_int("t1_valid_cycles", valid_cycles, 3);
    check_bit("t1_end", mend, 1'b1);
    check_bit("t1_timeout", mto, 1'b0);
    en = 1'b0; tick();
    check_bit("t1_end_drop", mend, 1'b0);
    disable_en();

    // Early response before the send-complete pulse
    valid_cycles = 0; windows = 0;
    en = 1'b1;
    wait_valid("t2_req");
    mv = 1'b1; rx = RESP_CODE; tick(); mv = 1'b0; rx = 4'b0000;
    fe_pulse();
    check_bit("t2_window_closed", vout, 1'b0);
    partner = 1'b1; tick();
    check_bit("t2_end", mend, 1'b1);
    check_int("t2_windows", windows, 1);
    disable_en();

    // Timeouts: three attempts then sticky error
    valid_cycles = 0; windows = 0;
    en = 1'b1;
    repeat (3) begin
      wait_valid("t3_req");
      tick();
      fe_pulse();
    end
    n = 0;
    while (mto !== 1'b1 && n < 40) begin tick(); n++; end
    check_bit("t3_timeout", mto, 1'b1);
    check_int("t3_windows", windows, 3);
    repeat (5) tick();
    check_bit("t3_timeout_sticky", mto, 1'b1);
    check_int("t3_windows_after", windows, 3);
    en = 1'b0; tick();
    check_bit("t3_timeout_clear", mto, 1'b0);
    disable_en();

    // Retry then success on the timeout cycle of the second attempt
    valid_cycles = 0; windows = 0;
    en = 1'b1;
    wait_valid("t4_req1");
    fe_pulse();
    wait_valid("t4_req2");
    fe_pulse();
    repeat (9) tick();
    mv = 1'b1; rx = RESP_CODE; tick(); mv = 1'b0; rx = 4'b0000;
    repeat (15) tick();
    check_int("t4_windows", windows, 2);
    check_bit("t4_timeout", mto, 1'b0);
    check_bit("t4_end_wait", mend, 1'b0);
    partner = 1'b1; tick();
    check_bit("t4_end", mend, 1'b1);
    disable_en();

    // Noise codes in WAIT_RESP do not stop the timer
    en = 1'b1;
    wait_valid("t5_req");
    fe_pulse();
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      mv = (k == 4) || (k == 5);
      rx = (k == 4) ? 4'b0001 : ((k == 5) ? 4'b0101 : 4'b0000);
      tick();
      n = k;
      if (vout === 1'b1) break;
    end
    mv = 1'b0; rx = 4'b0000;
    check_int("t5_next_request_cycle", n, 11);
    disable_en();

    // Aborts: enable drop in WAIT_PARTNER, then reset during SEND_REQ
    en = 1'b1;
    wait_valid("t6_req");
    fe_pulse();
    mv = 1'b1; rx = RESP_CODE; tick(); mv = 1'b0; rx = 4'b0000;
    en = 1'b0; tick();
    check_bit("t6_abort_end", mend, 1'b0);
    check_bit("t6_abort_valid", vout, 1'b0);
    en = 1'b1;
    wait_valid("t6_req2");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_bit("t6_async_valid", vout, 1'b0);
    check_nib("t6_async_tx", tx, 4'b0000);
    en = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check_bit("t6_no_request", vout, 1'b0);
    en = 1'b1;
    wait_valid("t6_reenable");
    disable_en();

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      en      = ($urandom_range(0, 79) != 0);
      busy    = $urandom_range(0, 1) == 1;
      fe      = ($urandom_range(0, 5) == 0);
      mv      = ($urandom_range(0, 7) == 0);
      partner = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       rx = 4'b0001;
        1:       rx = 4'b0010;
        2:       rx = 4'b0101;
        default: rx = 4'($urandom);
      endcase
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    disable_en();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cal_module_initiator.md
CAL_MODULE_INITIATOR -- requirements
Module: cal_module_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd8000, meaning WAIT_RESP cycles before one attempt times out.
REQ-002 SHALL have parameter MAX_RETRY, default 2, meaning request re-sends allowed after the first attempt.
REQ-003 SHALL have parameter MSG_CAL_DONE_REQ, default 4'b0001, meaning the request code.
REQ-004 SHALL have parameter MSG_CAL_DONE_RESP, default 4'b0010, meaning the response code.
REQ-005 CLK  in  1  single clock, rising edge; one clock; reset is asynchronous and active-low.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 i_MBINIT_PARAM_end  in  1  enable; high while the CAL phase is active.
REQ-008 i_RX_SbMessage  in  4  received sideband message code.
REQ-009 i_msg_valid  in  1  i_RX_SbMessage is valid this cycle.
REQ-010 i_Busy_SideBand  in  1  sideband TX busy.
REQ-011 i_falling_edge_busy  in  1  one-cycle pulse when the TX busy deasserts (message sent).
REQ-012 i_MBINIT_CAL_ModulePartner_end  in  1  local responder side finished.
REQ-013 o_TX_SbMessage  out  4  message to transmit.
REQ-014 o_ValidOutDatat_Module  out  1  o_TX_SbMessage valid.
REQ-015 o_MBINIT_CAL_Module_end  out  1  whole CAL handshake complete.
REQ-016 o_CAL_timeout  out  1  sticky failure after retries are exhausted.

Function
REQ-017 SHALL implement the states IDLE, WAIT_BUS_FREE, SEND_REQ, WAIT_RESP, WAIT_PARTNER, DONE and ERROR, with an unencoded default case going to IDLE.
REQ-018 SHALL go from any state other than IDLE to IDLE when i_MBINIT_PARAM_end=0; this check takes priority over every other transition.
REQ-019 SHALL go IDLE->WAIT_BUS_FREE on i_MBINIT_PARAM_end=1.
REQ-020 SHALL go WAIT_BUS_FREE->SEND_REQ when i_Busy_SideBand=0.
REQ-021 SHALL go SEND_REQ->WAIT_RESP on i_falling_edge_busy.
REQ-022 SHALL, on a falling edge in SEND_REQ with the response already latched, go directly to WAIT_PARTNER.
REQ-023 SHALL hold a resp_seen flag.
- Set by i_msg_valid=1 with i_RX_SbMessage=MSG_CAL_DONE_RESP while in SEND_REQ or WAIT_RESP.
- Cleared in IDLE.
- Other codes, or a response in any other state, are ignored.
REQ-024 SHALL go WAIT_RESP->WAIT_PARTNER when resp_seen is set, or when a valid response arrives this cycle.
REQ-025 SHALL go WAIT_PARTNER->DONE when i_MBINIT_CAL_ModulePartner_end=1.
REQ-026 SHALL, in WAIT_RESP with resp_seen set and partner end already high, go directly to DONE.
REQ-027 SHALL hold a timeout counter, width clog2(TIMEOUT_CYCLES+1).
- Cleared on entering WAIT_RESP; increments each WAIT_RESP cycle.
- Saturates; never wraps.
REQ-028 SHALL declare a timeout when the counter reaches TIMEOUT_CYCLES-1 with no response that cycle (a response in the same cycle wins).
REQ-029 SHALL, on timeout, increment retry_cnt and go to WAIT_BUS_FREE if retry_cnt<MAX_RETRY, otherwise go to ERROR.
REQ-030 SHALL clear retry_cnt in IDLE only.
REQ-031 SHALL hold ERROR until i_MBINIT_PARAM_end=0, and DONE likewise.
REQ-032 SHALL register all outputs, decoded from next_state, so outputs lag the state decision by one cycle.
REQ-033 SHALL default the outputs each cycle to 0.
- next_state=SEND_REQ: o_TX_SbMessage=MSG_CAL_DONE_REQ, o_ValidOutDatat_Module=1.
- next_state=DONE: o_MBINIT_CAL_Module_end=1.
- next_state=ERROR: o_CAL_timeout=1.
REQ-034 SHALL produce exactly one SEND_REQ window per attempt, and at most MAX_RETRY+1 requests per enable period.

Reset
REQ-035 SHALL, on rst_n=0, asynchronously force state=IDLE, all outputs=0, counter=0, retry_cnt=0 and resp_seen=0.
REQ-036 SHALL, on reset mid-handshake, not issue a request until i_MBINIT_PARAM_end is seen high after reset release.

Verification
REQ-037 Normal handshake: PARAM_end=1, busy=0, falling edge 3 cycles later, RESP 5 cycles later, partner_end=1 -> one valid cycle block with TX=0001, then end=1 held, timeout=0.
REQ-038 Early response: RESP arrives during SEND_REQ before the falling edge -> no WAIT_RESP dwell; end=1 once partner_end=1.
REQ-039 Timeouts: TIMEOUT_CYCLES=10 with no RESP -> three request windows (TX=0001), then timeout=1 sticky; PARAM_end=0 -> timeout=0 the next cycle.
REQ-040 Retry then success: TIMEOUT_CYCLES=10, RESP on the 2nd attempt's WAIT_RESP cycle 9 (the timeout cycle) -> no 3rd request; goes to WAIT_PARTNER.
REQ-041 Noise: a valid code 0001 or 0101 in WAIT_RESP -> ignored; counter keeps running.
REQ-042 Aborts: PARAM_end drops in WAIT_PARTNER -> IDLE with outputs 0; rst_n pulsed during SEND_REQ -> outputs 0 immediately, no request until re-enabled.
